// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory store path.
package mem_pkg;

    localparam logic [3:0]  BE_WORD          = 4'hF;
    localparam int unsigned SB_DEPTH_DEFAULT = 4;

    // One buffered store: word address, lane-aligned data and byte enables.
    typedef struct packed {
        logic        valid;
        logic [29:0] waddr;
        logic [31:0] data;
        logic [3:0]  be;
    } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// Youngest-first address match over the live store-buffer entries.
module sb_match
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH_DEFAULT,
    localparam int unsigned PW   = $clog2(DEPTH)
) (
    input  sb_entry_t        entries [DEPTH],
    input  logic [PW-1:0]    head,
    input  logic [PW:0]      count,
    input  logic [29:0]      ld_waddr,
    output logic [PW-1:0]    match_idx,
    output logic             match,
    output logic             full_word
);

    logic [PW-1:0] pos;

    // Walk from tail-1 (youngest) toward head; the first hit wins.
    always_comb begin
        match     = 1'b0;
        full_word = 1'b0;
        match_idx = '0;
        pos       = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            pos = head + PW'(int'(count) - 1 - k);
            if (!match && (k < int'(count)) && entries[pos].valid &&
                (entries[pos].waddr == ld_waddr)) begin
                match     = 1'b1;
                match_idx = pos;
                full_word = (entries[pos].be == BE_WORD);
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer between the MEM stage and the data memory write port.
// Optional macro STORE_FWD_EN: forward full-word matches to loads; when
// undefined, any word match stalls the load until the entry drains.
module store_buffer
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH_DEFAULT,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   st_valid,
    output logic                   st_ready,
    input  logic [AW-1:0]          st_addr,
    input  logic [DW-1:0]          st_data,
    input  logic [DW/8-1:0]        st_be,
    input  logic                   ld_valid,
    input  logic [AW-1:0]          ld_addr,
    output logic                   ld_fwd_hit,
    output logic [DW-1:0]          ld_fwd_data,
    output logic                   ld_stall,
    output logic                   mem_we,
    output logic [AW-1:0]          mem_addr,
    output logic [DW-1:0]          mem_wdata,
    output logic [DW/8-1:0]        mem_be,
    input  logic                   mem_ready,
    output logic                   sb_empty,
    output logic [$clog2(DEPTH):0] sb_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    sb_entry_t     entries_q [DEPTH];
    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;

    logic full, empty, push, pop;
    logic [PW-1:0] match_idx;
    logic          match, full_word;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    // No pass-through: a pop in the same cycle does not open a slot.
    assign push  = st_valid && !full;
    assign pop   = !empty && mem_ready;

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) tail_q <= tail_q + 1'b1;
            if (pop)  head_q <= head_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; push and pop never target the same slot in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) entries_q[i] <= '0;
        end else begin
            if (pop) entries_q[head_q].valid <= 1'b0;
            if (push) begin
                entries_q[tail_q] <= '{valid: 1'b1, waddr: st_addr[31:2],
                                       data: st_data, be: st_be};
            end
        end
    end

    assign st_ready  = !full;
    assign mem_we    = !empty;
    assign mem_addr  = {entries_q[head_q].waddr, 2'b00};
    assign mem_wdata = entries_q[head_q].data;
    assign mem_be    = entries_q[head_q].be;
    assign sb_empty  = empty;
    assign sb_count  = count_q;

    sb_match #(
        .DEPTH (DEPTH)
    ) u_match (
        .entries   (entries_q),
        .head      (head_q),
        .count     (count_q),
        .ld_waddr  (ld_addr[31:2]),
        .match_idx (match_idx),
        .match     (match),
        .full_word (full_word)
    );

    // Load lookup: forward a youngest full-word match, otherwise stall on any match.
    always_comb begin
        ld_fwd_hit  = 1'b0;
        ld_fwd_data = '0;
        ld_stall    = 1'b0;
`ifdef STORE_FWD_EN
        if (ld_valid && match) begin
            if (full_word) begin
                ld_fwd_hit  = 1'b1;
                ld_fwd_data = entries_q[match_idx].data;
            end else begin
                ld_stall = 1'b1;
            end
        end
`else
        if (ld_valid && match) ld_stall = 1'b1;
`endif
    end

`ifndef STORE_FWD_EN
    logic unused_match;
    assign unused_match = ^{match_idx, full_word};
`endif
    logic unused_low_bits;
    assign unused_low_bits = ^{st_addr[1:0], ld_addr[1:0]};

endmodule
